writeback_unit: RTL

Final pipeline stage of the multi-cycle MIPS CPU. It accepts a completed instruction from execute: either an ALU result or a load's effective address. For loads it runs the data-memory read handshake and aligns, extends or merges the returned word. It then drives the register file write port (write enable, 5-bit write address, 32-bit write data) for exactly one cycle per instruction.

---
 rtl/mips_pkg.sv | 32 +++
 rtl/load_align.sv | 39 +++
 rtl/writeback_unit.sv | 106 ++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared types for the multi-cycle MIPS pipeline: load opcodes, writeback FSM
// states and the hard-wired zero register.
package mips_pkg;

  typedef enum logic [2:0] {
    LW  = 3'd0,
    LB  = 3'd1,
    LBU = 3'd2,
    LH  = 3'd3,
    LHU = 3'd4,
    LWL = 3'd5,
    LWR = 3'd6
  } load_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } wb_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // LW needs a word boundary, LH/LHU a halfword boundary; the rest are byte-granular.
  function automatic logic is_misaligned(input load_op_t op, input logic [1:0] b);
    case (op)
      LW:      return b != 2'b00;
      LH, LHU: return b[0];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load data path: selects, extends or merges the returned
// memory word according to the load opcode and the byte offset.
module load_align
  import mips_pkg::*;
(
  input  load_op_t    load_op,
  input  logic [1:0]  b,
  input  logic [31:0] w,
  input  logic [31:0] rt_old,
  output logic [31:0] result
);

  logic [31:0] byte_shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [4:0]  sh_left;
  logic [4:0]  sh_right;

  // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    byte_shifted = w >> {b, 3'b000};
    byte_v       = byte_shifted[7:0];
    half_v       = b[1] ? w[31:16] : w[15:0];
    sh_left      = {~b, 3'b000};  // 8*(3-b)
    sh_right     = {b, 3'b000};   // 8*b
    result       = w;
    case (load_op)
      LW:      result = w;
      LB:      result = {{24{byte_v[7]}}, byte_v};
      LBU:     result = {24'd0, byte_v};
      LH:      result = {{16{half_v[15]}}, half_v};
      LHU:     result = {16'd0, half_v};
      LWL:     result = (w << sh_left) | (rt_old & ~(32'hFFFF_FFFF << sh_left));
      LWR:     result = (w >> sh_right) | (rt_old & ~(32'hFFFF_FFFF >> sh_right));
      default: result = w;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Final pipeline stage: retires ALU results directly, or runs a data-memory
// read for loads, aligns the word, then issues a one-cycle register write.
module writeback_unit
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_load,
  input  logic [2:0]        load_op,
  input  logic [4:0]        dest_reg,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       rt_old,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_address,
  input  logic              mem_waitrequest,
  input  logic [31:0]       mem_readdata,
  output logic              reg_write,
  output logic [4:0]        reg_write_addr,
  output logic [31:0]       reg_write_data,
  output logic              busy,
  output logic              done,
  output logic              addr_err
);

  wb_state_t         state, state_nxt;
  load_op_t          op_in, op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [4:0]        dest_q;
  logic [31:0]       data_q;
  logic [31:0]       rt_q;
  logic [31:0]       align_result;
  logic              bad_align;
  logic              accept;

  assign op_in     = load_op_t'(load_op);
  assign bad_align = is_load && is_misaligned(op_in, alu_result[1:0]);
  assign accept    = (state == IDLE) && start && !bad_align;

  load_align u_align (
    .load_op (op_q),
    .b       (addr_q[1:0]),
    .w       (mem_readdata),
    .rt_old  (rt_q),
    .result  (align_result)
  );

  // NOTE: all sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= LW;
      addr_q   <= '0;
      dest_q   <= REG_ZERO;
      data_q   <= '0;
      rt_q     <= '0;
      addr_err <= 1'b0;
    end else begin
      addr_err <= (state == IDLE) && start && bad_align;
      if (accept) begin
        op_q   <= op_in;
        addr_q <= alu_result[ADDR_W-1:0];
        dest_q <= dest_reg;
        data_q <= alu_result;
        rt_q   <= rt_old;
      end else if (state == READ && !mem_waitrequest) begin
        data_q <= align_result;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    mem_read       = 1'b0;
    reg_write      = 1'b0;
    reg_write_addr = '0;
    reg_write_data = '0;
    done           = 1'b0;
    busy           = (state != IDLE);
    case (state)
      IDLE:  if (accept) state_nxt = is_load ? READ : WRITE;
      READ: begin
        mem_read = 1'b1;
        if (!mem_waitrequest) state_nxt = WRITE;
      end
      WRITE: begin
        done           = 1'b1;
        reg_write      = (dest_q != REG_ZERO);
        reg_write_addr = dest_q;
        reg_write_data = data_q;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address stays constant for the whole read because addr_q only loads in IDLE.
  assign mem_address = {addr_q[ADDR_W-1:2], 2'b00};

endmodule
